// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - control and display bundle of the stopwatch counter
interface stopwatch_counter_if #(
    parameter int W = 6
);
    logic         tick_1hz;
    logic         tick_adj;
    logic         pause_btn;
    logic         adj;
    logic         sel;
    logic         down;
    logic [W-1:0] minutes;
    logic [W-1:0] seconds;
    logic [3:0]   min_tens;
    logic [3:0]   min_ones;
    logic [3:0]   sec_tens;
    logic [3:0]   sec_ones;
    logic         running;
    logic         wrap;
    logic         done;

    modport master (
        output tick_1hz, tick_adj, pause_btn, adj, sel, down,
        input  minutes, seconds, min_tens, min_ones, sec_tens, sec_ones,
        input  running, wrap, done
    );

    modport slave (
        input  tick_1hz, tick_adj, pause_btn, adj, sel, down,
        output minutes, seconds, min_tens, min_ones, sec_tens, sec_ones,
        output running, wrap, done
    );
endinterface

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - minutes:seconds counter with pause, adjust, up/down and BCD digits
module stopwatch_counter #(
    parameter int W       = 6,
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_counter_if.slave   bus
);
    typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_ADJUST} state_t;

    localparam logic [W-1:0] MIN_TOP = W'(MAX_MIN);
    localparam logic [W-1:0] SEC_TOP = W'(MAX_SEC);

    state_t       state_q, state_d;
    logic         resume_to_q, resume_to_d;
    logic [W-1:0] min_q, min_d;
    logic [W-1:0] sec_q, sec_d;
    logic         wrap_q, wrap_d;
    logic         done_q, done_d;
    logic         running_q, running_d;
    logic         down_tick;
    logic [3:0]   min_tens_q, min_tens_d, min_ones_q, min_ones_d;
    logic [3:0]   sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;

    // Fields never exceed 99, so an 8-bit divide is always wide enough.
    function automatic logic [3:0] tens_of(input logic [W-1:0] v);
        logic [7:0] v8;
        v8 = 8'(v);
        return 4'(v8 / 8'd10);
    endfunction

    function automatic logic [3:0] ones_of(input logic [W-1:0] v);
        logic [7:0] v8;
        v8 = 8'(v);
        return 4'(v8 % 8'd10);
    endfunction

    always_comb begin
        state_d     = state_q;
        resume_to_d = resume_to_q;
        min_d       = min_q;
        sec_d       = sec_q;
        wrap_d      = 1'b0;
        down_tick   = 1'b0;
        case (state_q)
            ST_ADJUST: begin
                if (!bus.adj) begin
                    state_d = resume_to_q ? ST_RUN : ST_PAUSE;
                end else if (bus.tick_adj) begin
                    if (bus.sel) begin
                        sec_d = (sec_q == SEC_TOP) ? '0 : sec_q + 1'b1;
                    end else begin
                        min_d = (min_q == MIN_TOP) ? '0 : min_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.adj) begin
                    state_d     = ST_ADJUST;
                    resume_to_d = 1'b1;
                end else begin
                    if (bus.pause_btn) begin
                        state_d = ST_PAUSE;
                    end
                    if (bus.tick_1hz && !bus.down) begin
                        if (sec_q != SEC_TOP) begin
                            sec_d = sec_q + 1'b1;
                        end else begin
                            sec_d = '0;
                            if (min_q == MIN_TOP) begin
                                min_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                min_d = min_q + 1'b1;
                            end
                        end
                    end else if (bus.tick_1hz) begin
                        down_tick = 1'b1;
                        if (sec_q != '0) begin
                            sec_d = sec_q - 1'b1;
                        end else if (min_q != '0) begin
                            sec_d = SEC_TOP;
                            min_d = min_q - 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.adj) begin
                    state_d     = ST_ADJUST;
                    resume_to_d = 1'b0;
                end else if (bus.pause_btn) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // done is raised only by a countdown tick and drops once the count leaves 00:00.
        done_d     = (down_tick || done_q) && (min_d == '0) && (sec_d == '0);
        running_d  = (state_d == ST_RUN);
        min_tens_d = tens_of(min_q);
        min_ones_d = ones_of(min_q);
        sec_tens_d = tens_of(sec_q);
        sec_ones_d = ones_of(sec_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            resume_to_q <= 1'b1;
            min_q       <= '0;
            sec_q       <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            running_q   <= 1'b1;
            min_tens_q  <= '0;
            min_ones_q  <= '0;
            sec_tens_q  <= '0;
            sec_ones_q  <= '0;
        end else begin
            state_q     <= state_d;
            resume_to_q <= resume_to_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            running_q   <= running_d;
            min_tens_q  <= min_tens_d;
            min_ones_q  <= min_ones_d;
            sec_tens_q  <= sec_tens_d;
            sec_ones_q  <= sec_ones_d;
        end
    end

    assign bus.minutes  = min_q;
    assign bus.seconds  = sec_q;
    assign bus.min_tens = min_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.sec_ones = sec_ones_q;
    assign bus.running  = running_q;
    assign bus.wrap     = wrap_q;
    assign bus.done     = done_q;
endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Parametrised minutes:seconds counter for the stopwatch datapath. It sits between the tick generators and the seven-segment display driver. It runs from the single system clock with tick-enable inputs rather than a derived clock. It adds synchronous reset, pause/resume, an adjust mode, selectable up/down counting with a countdown-done flag, correct wrap at the top count, and registered BCD digit outputs.

## Interface
Parameters:
- `W`, 6: width of the `minutes` and `seconds` fields. Constraint: `MAX_MIN < 2**W` and `MAX_SEC < 2**W`.
- `MAX_MIN`, 59: top value of minutes. Must be ≤ 99.
- `MAX_SEC`, 59: top value of seconds. Must be ≤ 99.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high. Highest priority.
- `tick_1hz`  in  1  one-cycle count-enable pulse.
- `tick_adj`  in  1  one-cycle adjust-rate pulse (2 Hz nominal).
- `pause_btn`  in  1  one-cycle debounced pulse that toggles run/pause.
- `adj`  in  1  level. 1 = adjust mode.
- `sel`  in  1  adjust field select. 0 = minutes, 1 = seconds.
- `down`  in  1  level. 1 = count down, 0 = count up.
- `minutes`  out  W  current minutes.
- `seconds`  out  W  current seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  registered BCD digits.
- `running`  out  1  1 when in RUN state.
- `wrap`  out  1  one-cycle pulse on the up-count wrap MAX:MAX → 00:00.
- `done`  out  1  level. Countdown has reached 00:00.

## Operation
- States: RUN, PAUSE, ADJUST. A one-bit `resume_to` register remembers whether to return to RUN or PAUSE on ADJUST exit.
- Reset:
  - State goes to RUN.
  - `minutes`, `seconds`, and all digits clear to 0.
  - `wrap` and `done` clear to 0. `running` is 1.
- Priority each cycle: reset > adj > pause_btn > tick_1hz.
- Transitions:
  - RUN or PAUSE with `adj`=1 → ADJUST, latching `resume_to`.
  - ADJUST with `adj`=0 → `resume_to`.
  - RUN with `pause_btn` → PAUSE.
  - PAUSE with `pause_btn` → RUN.
  - `pause_btn` is ignored in ADJUST.
- RUN, up (`down`=0), on `tick_1hz`:
  - If seconds < MAX_SEC: seconds+1.
  - Otherwise: seconds→0, and minutes+1, or minutes→0 if minutes==MAX_MIN.
  - The MAX_MIN:MAX_SEC → 0:0 transition pulses `wrap` for exactly one cycle.
- RUN, down (`down`=1), on `tick_1hz`:
  - At 00:00: hold, with `done`=1.
  - Else if seconds==0: seconds→MAX_SEC, minutes−1.
  - Else: seconds−1.
  - `done` is set in the same cycle the count becomes 00:00.
  - `done` clears when the count leaves 00:00 (adjust or up-count) or on reset.
  - No underflow ever occurs.
- PAUSE: the count holds and ticks are ignored.
- ADJUST:
  - Normal counting is suspended.
  - On `tick_adj`, the field chosen by `sel` increments by 1 and wraps MAX→0.
  - There is no carry into the other field, and `wrap` is not pulsed.
  - `tick_1hz` is ignored.
- Arithmetic:
  - Unsigned, W bits. Fields never exceed their MAX.
  - Digits: tens = value/10, ones = value%10, computed from the registered count.

## Timing
- The count updates on the clock edge where the qualifying tick is sampled high (1-cycle latency from tick).
- BCD digits lag the count by exactly 1 cycle.
- `wrap` is asserted in the same cycle the count shows 00:00.
- `running` and state update on the edge that samples `pause_btn`/`adj`.
- Simultaneous events:
  - RUN with `pause_btn` and `tick_1hz` together: the tick is counted and the state becomes PAUSE.
  - PAUSE with `pause_btn` and `tick_1hz` together: the tick is not counted and the state becomes RUN.
  - `adj` rising together with `tick_1hz`: no count.
- Reset mid-operation takes effect on the next edge regardless of state or ticks.
- Changing `down` takes effect on the next `tick_1hz`. It does not alter the current count.

## Test plan
- Reset, then 61 `tick_1hz` pulses (up) → minutes=1, seconds=1. Digits read 0,1,0,1 one cycle after the count update.
- Preload 59:59 via adjust, exit adjust, one tick → 00:00, `wrap`=1 for one cycle, minutes ≠ 60 at any point.
- `down`=1 from 01:00: 59 ticks → 00:01, one more → 00:00 with `done`=1, a further tick → holds 00:00.
- Pause: `pause_btn` and `tick_1hz` in the same cycle at 00:10 → 00:11 and `running`=0. Then 5 ticks → still 00:11. `pause_btn` again → `running`=1.
- Adjust with `sel`=1 at seconds=58, 3 `tick_adj` pulses → seconds=1 and minutes unchanged, `tick_1hz` ignored. Exit → returns to the prior PAUSE/RUN state.
- Assert `reset` during ADJUST at 12:34 → next cycle 00:00, RUN, `done`=0, `wrap`=0.
